// File: rtl/pwl_synth_pkg.sv
// Shared definitions for the PWL synth channel scheduler.
// Holds the config field-select encodings, the scheduler FSM state
// encodings and the channel mode definitions used by the channel ALU.
package pwl_synth_pkg;

    localparam int CFG_WDATA_BITS    = 16;
    localparam int CHANNEL_MODE_BITS = 2;

    // cfg_field values selecting which shadow field a config write targets
    typedef enum logic [2:0] {
        FLD_MANTISSA     = 3'd0,
        FLD_OCTAVE       = 3'd1,
        FLD_DETUNE_EXP   = 3'd2,
        FLD_TRI_OFFSET   = 3'd3,
        FLD_SLOPE_EXP    = 3'd4,
        FLD_SLOPE_OFFSET = 3'd5,
        FLD_AMP          = 3'd6,
        FLD_CHANNEL_MODE = 3'd7
    } cfg_field_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } sched_state_e;

    typedef enum logic [CHANNEL_MODE_BITS-1:0] {
        CM_SAW   = 2'd0,
        CM_TRI   = 2'd1,
        CM_PWL   = 2'd2,
        CM_NOISE = 2'd3
    } channel_mode_e;

endpackage

// File: rtl/pwls_channel_regs.sv
// Per-channel shadow/active parameter register pair.
// The host writes the shadow bank at any time; the active bank, which feeds
// the ALU, is loaded from the shadow bank only on i_copy (frame start).
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_we              write strobe, already qualified with this channel
//   i_field, i_wdata  field select and LSB-aligned write data
//   i_copy            load active bank from shadow (write bypass included)
//   o_*               active bank fields
module pwls_channel_regs
    import pwl_synth_pkg::*;
#(
    parameter int BITS            = 12,
    parameter int OCT_BITS        = 3,
    parameter int MANTISSA_BITS   = 10,
    parameter int DETUNE_EXP_BITS = 3,
    parameter int SLOPE_EXP_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_we,
    input  cfg_field_e                   i_field,
    input  logic [CFG_WDATA_BITS-1:0]    i_wdata,
    input  logic                         i_copy,
    output logic [MANTISSA_BITS-1:0]     o_mantissa,
    output logic [OCT_BITS-1:0]          o_octave,
    output logic [DETUNE_EXP_BITS-1:0]   o_detune_exp,
    output logic [BITS-1:0]              o_tri_offset,
    output logic [SLOPE_EXP_BITS-1:0]    o_slope_exp,
    output logic [BITS-1:0]              o_slope_offset,
    output logic [BITS-1:0]              o_amp,
    output logic [CHANNEL_MODE_BITS-1:0] o_channel_mode
);

    logic [MANTISSA_BITS-1:0]     r_sh_mant,   w_sh_mant;
    logic [OCT_BITS-1:0]          r_sh_oct,    w_sh_oct;
    logic [DETUNE_EXP_BITS-1:0]   r_sh_dexp,   w_sh_dexp;
    logic [BITS-1:0]              r_sh_toff,   w_sh_toff;
    logic [SLOPE_EXP_BITS-1:0]    r_sh_sexp,   w_sh_sexp;
    logic [BITS-1:0]              r_sh_soff,   w_sh_soff;
    logic [BITS-1:0]              r_sh_amp,    w_sh_amp;
    logic [CHANNEL_MODE_BITS-1:0] r_sh_mode,   w_sh_mode;

    // Upper write-data bits beyond the widest field are deliberately dropped
    logic w_unused_wdata;
    assign w_unused_wdata = ^i_wdata[CFG_WDATA_BITS-1:BITS];

    // Next shadow value; also the copy source so a same-cycle write is captured
    always_comb begin
        w_sh_mant = r_sh_mant;
        w_sh_oct  = r_sh_oct;
        w_sh_dexp = r_sh_dexp;
        w_sh_toff = r_sh_toff;
        w_sh_sexp = r_sh_sexp;
        w_sh_soff = r_sh_soff;
        w_sh_amp  = r_sh_amp;
        w_sh_mode = r_sh_mode;
        if (i_we) begin
            case (i_field)
                FLD_MANTISSA:     w_sh_mant = i_wdata[MANTISSA_BITS-1:0];
                FLD_OCTAVE:       w_sh_oct  = i_wdata[OCT_BITS-1:0];
                FLD_DETUNE_EXP:   w_sh_dexp = i_wdata[DETUNE_EXP_BITS-1:0];
                FLD_TRI_OFFSET:   w_sh_toff = i_wdata[BITS-1:0];
                FLD_SLOPE_EXP:    w_sh_sexp = i_wdata[SLOPE_EXP_BITS-1:0];
                FLD_SLOPE_OFFSET: w_sh_soff = i_wdata[BITS-1:0];
                FLD_AMP:          w_sh_amp  = i_wdata[BITS-1:0];
                FLD_CHANNEL_MODE: w_sh_mode = i_wdata[CHANNEL_MODE_BITS-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_mant <= '0;
            r_sh_oct  <= '0;
            r_sh_dexp <= '0;
            r_sh_toff <= '0;
            r_sh_sexp <= '0;
            r_sh_soff <= '0;
            r_sh_amp  <= '1;
            r_sh_mode <= '0;
        end else begin
            r_sh_mant <= w_sh_mant;
            r_sh_oct  <= w_sh_oct;
            r_sh_dexp <= w_sh_dexp;
            r_sh_toff <= w_sh_toff;
            r_sh_sexp <= w_sh_sexp;
            r_sh_soff <= w_sh_soff;
            r_sh_amp  <= w_sh_amp;
            r_sh_mode <= w_sh_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_mantissa     <= '0;
            o_octave       <= '0;
            o_detune_exp   <= '0;
            o_tri_offset   <= '0;
            o_slope_exp    <= '0;
            o_slope_offset <= '0;
            o_amp          <= '1;
            o_channel_mode <= '0;
        end else if (i_copy) begin
            o_mantissa     <= w_sh_mant;
            o_octave       <= w_sh_oct;
            o_detune_exp   <= w_sh_dexp;
            o_tri_offset   <= w_sh_toff;
            o_slope_exp    <= w_sh_sexp;
            o_slope_offset <= w_sh_soff;
            o_amp          <= w_sh_amp;
            o_channel_mode <= w_sh_mode;
        end
    end

endmodule

// File: rtl/pwls_channel_scheduler.sv
// Time-multiplexed channel scheduler: on each sample_tick it walks the
// enabled channels, issues one ALU evaluation per channel, sums the results
// in a widened accumulator and emits one saturated sample per frame.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   sample_tick, ch_enable       frame start pulse and per-channel enable mask
//   cfg_we/ch/field/wdata        host shadow-register write port
//   alu_start, alu_ch, params    ALU request and active parameters of alu_ch
//   alu_done, alu_out            ALU response
//   sample_out, sample_valid     mixed sample and its one-cycle strobe
//   busy, overrun, overrun_clr   status: frame in progress, sticky tick overrun
module pwls_channel_scheduler
    import pwl_synth_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int BITS            = 12,
    parameter int OCT_BITS        = 3,
    parameter int MANTISSA_BITS   = 10,
    parameter int DETUNE_EXP_BITS = 3,
    parameter int SLOPE_EXP_BITS  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_tick,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]    cfg_ch,
    input  logic [2:0]                   cfg_field,
    input  logic [CFG_WDATA_BITS-1:0]    cfg_wdata,
    output logic                         alu_start,
    output logic [$clog2(NUM_CH)-1:0]    alu_ch,
    output logic [MANTISSA_BITS-1:0]     mantissa,
    output logic [OCT_BITS-1:0]          octave,
    output logic [DETUNE_EXP_BITS-1:0]   detune_exp,
    output logic [BITS-1:0]              tri_offset,
    output logic [SLOPE_EXP_BITS-1:0]    slope_exp,
    output logic [BITS-1:0]              slope_offset,
    output logic [BITS-1:0]              amp,
    output logic [CHANNEL_MODE_BITS-1:0] channel_mode,
    input  logic                         alu_done,
    input  logic signed [BITS-1:0]       alu_out,
    output logic signed [BITS-1:0]       sample_out,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int CW    = $clog2(NUM_CH);
    localparam int ACC_W = BITS + CW;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2**(BITS-1) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2**(BITS-1)));

    sched_state_e             r_state, w_next;
    logic [CW-1:0]            r_ch;
    logic [NUM_CH-1:0]        r_en;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_ext;
    logic signed [BITS-1:0]   r_sample, w_sat;
    logic                     r_valid, r_overrun;
    logic                     w_copy, w_start, w_last;

    logic [MANTISSA_BITS-1:0]     w_mant [NUM_CH];
    logic [OCT_BITS-1:0]          w_oct  [NUM_CH];
    logic [DETUNE_EXP_BITS-1:0]   w_dexp [NUM_CH];
    logic [BITS-1:0]              w_toff [NUM_CH];
    logic [SLOPE_EXP_BITS-1:0]    w_sexp [NUM_CH];
    logic [BITS-1:0]              w_soff [NUM_CH];
    logic [BITS-1:0]              w_amp  [NUM_CH];
    logic [CHANNEL_MODE_BITS-1:0] w_mode [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwls_channel_regs #(
            .BITS(BITS), .OCT_BITS(OCT_BITS), .MANTISSA_BITS(MANTISSA_BITS),
            .DETUNE_EXP_BITS(DETUNE_EXP_BITS), .SLOPE_EXP_BITS(SLOPE_EXP_BITS)
        ) u_regs (
            .clk            (clk),
            .reset          (reset),
            .i_we           (cfg_we && (cfg_ch == CW'(g))),
            .i_field        (cfg_field_e'(cfg_field)),
            .i_wdata        (cfg_wdata),
            .i_copy         (w_copy),
            .o_mantissa     (w_mant[g]),
            .o_octave       (w_oct[g]),
            .o_detune_exp   (w_dexp[g]),
            .o_tri_offset   (w_toff[g]),
            .o_slope_exp    (w_sexp[g]),
            .o_slope_offset (w_soff[g]),
            .o_amp          (w_amp[g]),
            .o_channel_mode (w_mode[g])
        );
    end

    // r_ch and the active banks only move outside WAIT, so these are
    // stable from alu_start through alu_done.
    assign mantissa     = w_mant[r_ch];
    assign octave       = w_oct[r_ch];
    assign detune_exp   = w_dexp[r_ch];
    assign tri_offset   = w_toff[r_ch];
    assign slope_exp    = w_sexp[r_ch];
    assign slope_offset = w_soff[r_ch];
    assign amp          = w_amp[r_ch];
    assign channel_mode = w_mode[r_ch];

    assign alu_ch       = r_ch;
    assign alu_start    = w_start;
    assign busy         = (r_state != ST_IDLE);
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

    assign w_last = (r_ch == CW'(NUM_CH - 1));
    assign w_ext  = {{CW{alu_out[BITS-1]}}, alu_out};

    always_comb begin
        w_sat = r_acc[BITS-1:0];
        if (r_acc > ACC_MAX)      w_sat = {1'b0, {(BITS-1){1'b1}}};
        else if (r_acc < ACC_MIN) w_sat = {1'b1, {(BITS-1){1'b0}}};
    end

    always_comb begin
        w_next  = r_state;
        w_copy  = 1'b0;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: if (sample_tick) begin
                w_next = ST_ISSUE;
                w_copy = 1'b1;
            end
            ST_ISSUE: if (r_en[r_ch]) begin
                w_start = 1'b1;
                w_next  = ST_WAIT;
            end else begin
                w_next  = w_last ? ST_FINISH : ST_ISSUE;
            end
            ST_WAIT: if (alu_done) w_next = w_last ? ST_FINISH : ST_ISSUE;
            ST_FINISH: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_en      <= '0;
            r_acc     <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: if (sample_tick) begin
                    r_ch  <= '0;
                    r_acc <= '0;
                    r_en  <= ch_enable;
                end
                ST_ISSUE: if (!r_en[r_ch] && !w_last) r_ch <= r_ch + CW'(1);
                ST_WAIT: if (alu_done) begin
                    r_acc <= r_acc + w_ext;
                    if (!w_last) r_ch <= r_ch + CW'(1);
                end
                ST_FINISH: r_sample <= w_sat;
                default: ;
            endcase
            // A set event takes priority over a simultaneous clear
            if (sample_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
            else if (overrun_clr)                    r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwls_channel_scheduler.sv
module tb_pwls_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int BITS   = 12;
    localparam int K      = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    sample_tick = 1'b0;
    logic [NUM_CH-1:0]       ch_enable = '0;
    logic                    cfg_we = 1'b0;
    logic [1:0]              cfg_ch = '0;
    logic [2:0]              cfg_field = '0;
    logic [15:0]             cfg_wdata = '0;
    logic                    alu_start;
    logic [1:0]              alu_ch;
    logic [9:0]              mantissa;
    logic [2:0]              octave;
    logic [2:0]              detune_exp;
    logic [BITS-1:0]         tri_offset;
    logic [3:0]              slope_exp;
    logic [BITS-1:0]         slope_offset;
    logic [BITS-1:0]         amp;
    logic [1:0]              channel_mode;
    logic                    alu_done = 1'b0;
    logic signed [BITS-1:0]  alu_out = '0;
    logic signed [BITS-1:0]  sample_out;
    logic                    sample_valid;
    logic                    busy;
    logic                    overrun;
    logic                    overrun_clr = 1'b0;

    pwls_channel_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick), .ch_enable(ch_enable),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
        .alu_start(alu_start), .alu_ch(alu_ch), .mantissa(mantissa), .octave(octave),
        .detune_exp(detune_exp), .tri_offset(tri_offset), .slope_exp(slope_exp),
        .slope_offset(slope_offset), .amp(amp), .channel_mode(channel_mode),
        .alu_done(alu_done), .alu_out(alu_out), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int vcount  = 0;
    int alu_mode = 0;
    int starts[$];
    int amp_seen  [NUM_CH];
    int mant_seen [NUM_CH];

    typedef struct { int val; int tcyc; int lat; } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural ALU: alu_done K cycles after alu_start, result by alu_mode
    initial begin : alu_model
        int cnt;
        int cur;
        cnt = 0;
        cur = 0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    alu_done = 1'b1;
                    case (alu_mode)
                        0:       alu_out = BITS'(100 * (cur + 1));
                        1:       alu_out = BITS'(2047);
                        default: alu_out = BITS'(-2048);
                    endcase
                end
            end
            if (alu_start) begin
                cnt = K;
                cur = int'(alu_ch);
                starts.push_back(cur);
                amp_seen[cur]  = int'(amp);
                mant_seen[cur] = int'(mantissa);
            end
        end
    end

    // Output monitor: pop expected sample and latency on each sample_valid
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && sample_valid) begin
                vcount++;
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("sample_out", int'(sample_out), e.val);
                    if (e.lat >= 0) chk("latency", cyc - e.tcyc, e.lat);
                end
            end
        end
    end

    task automatic tick(input logic [NUM_CH-1:0] en, input int val, input int lat, input bit push);
        exp_t e;
        sample_tick = 1'b1;
        ch_enable   = en;
        if (push) begin
            e.val = val; e.tcyc = cyc; e.lat = lat;
            sb.push_back(e);
        end
        @(negedge clk);
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic wr(input int c, input int f, input logic [15:0] d);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_field = 3'(f); cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("frame_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int v0;
        repeat (2) @(negedge clk);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_sample_valid", int'(sample_valid), 0);
        chk("rst_alu_start", int'(alu_start), 0);
        chk("rst_alu_ch", int'(alu_ch), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_amp", int'(amp), 4095);
        chk("rst_mantissa", int'(mantissa), 0);
        reset = 1'b0;
        @(negedge clk);

        // All channels enabled
        starts.delete();
        tick(4'b1111, 1000, 18, 1);
        chk("all_busy", int'(busy), 1);
        wait_idle();
        chk("all_nstarts", starts.size(), 4);
        for (int i = 0; i < starts.size() && i < 4; i++) chk("all_order", starts[i], i);

        // Sparse enable mask
        starts.delete();
        tick(4'b0101, 400, 12, 1);
        wait_idle();
        chk("mask_nstarts", starts.size(), 2);
        if (starts.size() == 2) begin
            chk("mask_first", starts[0], 0);
            chk("mask_second", starts[1], 2);
        end

        // No channel enabled
        starts.delete();
        tick(4'b0000, 0, 6, 1);
        wait_idle();
        chk("none_nstarts", starts.size(), 0);

        // Saturation at both ends
        alu_mode = 1;
        tick(4'b1111, 2047, 18, 1);
        wait_idle();
        alu_mode = 2;
        tick(4'b1111, -2048, 18, 1);
        wait_idle();
        alu_mode = 0;

        // Field truncation: upper write bits dropped
        wr(2, 0, 16'hFFFF);
        tick(4'b1111, 1000, 18, 1);
        wait_idle();
        chk("trunc_mantissa", mant_seen[2], 1023);

        // Overrun: second tick 5 cycles after the first
        v0 = vcount;
        tick(4'b1111, 1000, 18, 1);
        repeat (4) @(negedge clk);
        tick(4'b1111, 0, 0, 0);
        chk("ovr_set", int'(overrun), 1);
        wait_idle();
        chk("ovr_one_valid", vcount - v0, 1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        chk("ovr_clr", int'(overrun), 0);

        // Set wins over simultaneous clear
        tick(4'b1111, 1000, -1, 1);
        overrun_clr = 1'b1;
        tick(4'b1111, 0, 0, 0);
        chk("ovr_set_wins", int'(overrun), 1);
        wait_idle();
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        // Amp written mid-frame only takes effect on the next frame
        tick(4'b1111, 1000, 18, 1);
        wr(1, 6, 16'd5);
        wait_idle();
        chk("amp_midframe", amp_seen[1], 4095);
        tick(4'b1111, 1000, 18, 1);
        wait_idle();
        chk("amp_nextframe", amp_seen[1], 5);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_field = 3'd6; cfg_wdata = 16'd9;
        tick(4'b1111, 1000, 18, 1);
        wait_idle();
        chk("amp_bypass", amp_seen[1], 9);

        // Reset while waiting on the ALU
        v0 = vcount;
        tick(4'b1111, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstwait_busy", int'(busy), 0);
        chk("rstwait_valid", int'(sample_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("rstwait_no_valid", vcount - v0, 0);
        tick(4'b1111, 1000, 18, 1);
        wait_idle();
        chk("rstwait_amp_reset", amp_seen[1], 4095);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pwls_channel_scheduler.md
PWLS_CHANNEL_SCHEDULER -- requirements
Module: pwls_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of time-multiplexed channels (power of two, 2..8).
REQ-002 SHALL have parameters BITS=12, OCT_BITS=3, MANTISSA_BITS=10, DETUNE_EXP_BITS=3, SLOPE_EXP_BITS=4: widths matching the channel ALU.
REQ-003 SHALL have these ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle pulse that starts a frame.
- ch_enable  in  NUM_CH  per-channel enable mask, sampled at frame start.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  log2(NUM_CH)  channel being written.
- cfg_field  in  3  field: 0 mantissa, 1 octave, 2 detune_exp, 3 tri_offset, 4 slope_exp, 5 slope_offset, 6 amp, 7 channel_mode.
- cfg_wdata  in  16  LSB-aligned value; upper bits are ignored.
- alu_start  out  1  one-cycle pulse requesting an ALU evaluation.
- alu_ch  out  log2(NUM_CH)  channel being evaluated.
- mantissa, octave, detune_exp, tri_offset, slope_exp, slope_offset, amp, channel_mode  out  ALU widths  active parameters of channel alu_ch.
- alu_done  in  1  one-cycle pulse: ALU result valid.
- alu_out  in  BITS  signed ALU result.
- sample_out  out  BITS  signed mixed sample.
- sample_valid  out  1  one-cycle pulse: sample_out updated.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky overrun flag.
- overrun_clr  in  1  clears overrun.

Function
REQ-004 SHALL hold two register banks per channel: shadow (host-written) and active (drives the ALU).
REQ-005 Each cfg_we cycle SHALL write cfg_wdata, truncated to the field width, into the addressed shadow field; writes are accepted in every state.
REQ-006 On sample_tick in IDLE, SHALL copy every shadow bank to its active bank and latch ch_enable.
REQ-007 A cfg write in the same cycle as that copy SHALL be included in the copy (write bypass).
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, FINISH.
- IDLE --sample_tick--> ISSUE, with ch=0 and acc=0.
- ISSUE, channel enabled: assert alu_start for one cycle, alu_ch=ch, go to WAIT.
- ISSUE, channel disabled: no alu_start; advance ch, or go to FINISH after the last channel.
- WAIT --alu_done--> acc += sign-extended alu_out; advance ch to ISSUE, or go to FINISH after the last channel.
- FINISH: sample_out <= acc saturated to signed BITS, sample_valid=1 for one cycle, then IDLE.
REQ-009 Accumulator width SHALL be BITS+log2(NUM_CH), signed, so it cannot overflow internally; saturation limits are -2^(BITS-1) and 2^(BITS-1)-1.
REQ-010 ALU parameter outputs SHALL be combinational muxes of the active bank by alu_ch, and SHALL be stable from alu_start through alu_done.
REQ-011 alu_done outside WAIT SHALL be ignored.
REQ-012 sample_tick outside IDLE SHALL be ignored and SHALL set overrun.
REQ-013 overrun_clr SHALL clear overrun; if overrun_clr and a set event occur in the same cycle, set wins.
REQ-014 busy SHALL be high in ISSUE, WAIT and FINISH.
REQ-015 Frame latency with all channels enabled and a k-cycle ALU: sample_valid occurs NUM_CH*(k+1)+2 cycles after sample_tick.
REQ-016 A frame with all channels disabled SHALL produce sample_out=0, with sample_valid NUM_CH+2 cycles after the tick.

Reset
REQ-017 Reset SHALL be asynchronous: the FSM goes to IDLE and any frame in progress is abandoned with no sample_valid.
REQ-018 Reset values SHALL be:
- Outputs: sample_out=0, sample_valid=0, alu_start=0, alu_ch=0, busy=0, overrun=0.
- Internal: acc=0, latched enables=0.
- Shadow and active banks: all fields 0 except amp, which resets to all ones.

Structure
REQ-019 Field-select encodings (cfg_field values) and FSM state encodings SHALL live in the shared pwl_synth package/header, next to the CHANNEL_MODE definitions.
REQ-020 The per-channel shadow/active register pair SHALL be one sub-module, pwls_channel_regs, instantiated NUM_CH times.

Verification
REQ-021 The bench SHALL cover these directed scenarios, using a behavioural ALU model with k=3 that returns 100*(ch+1):
- All enabled, one tick -> alu_start for ch 0,1,2,3 in order; sample_out=1000; sample_valid 18 cycles after the tick.
- ch_enable=4'b0101 -> alu_start only for ch0 and ch2; sample_out=400.
- ALU model returns 2047 for every channel -> sample_out=2047 (saturated). Returns -2048 for every channel -> sample_out=-2048.
- Second tick 5 cycles after the first -> overrun=1 and only one sample_valid; overrun_clr -> overrun=0.
- Write amp of ch1 during a frame -> unchanged in that frame, new value visible on the next frame. Write in the same cycle as the tick -> used in that frame.
- Reset asserted in WAIT -> busy=0 immediately, no sample_valid; a following tick runs a clean frame.
